mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-ported unified memory between the pipelined core's instruction-fetch port and its data port. Sits between the core's PC/Instr and ALUResult/WriteData/MemWrite/ReadData nets and one external memory using a req/ack handshake. It serialises the two accesses and holds the pipeline with a stall signal until both are served. The stall is intended to be ORed into the hazard unit's stallF/stallD.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 255, maximum cycles in a busy state without m_ack before a timeout abort

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level, held while stall=1
- i_addr  in  AW  fetch address (PC)
- i_rdata  out  DW  fetched instruction, registered
- d_req  in  1  data request, level, held while stall=1
- d_we  in  1  1=write, 0=read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  read data, registered
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  AW  memory address, registered
- m_wdata  out  DW  memory write data, registered
- m_rdata  in  DW  memory read data, valid with m_ack
- m_ack  in  1  memory completion, one cycle per transaction
- stall  out  1  combinational: (i_req & ~i_done) | (d_req & ~d_done)
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE, D_BUSY, I_BUSY. Internal done bits: i_done and d_done.
- IDLE:
  - d_req & ~d_done → D_BUSY. Latch d_addr/d_we/d_wdata into m_*.
  - Otherwise, i_req & ~i_done → I_BUSY. Latch i_addr, with m_we=0.
  - Data has fixed priority over fetch, so the older instruction's access completes first.
- D_BUSY / I_BUSY:
  - m_req=1 and m_* are stable until m_ack.
  - On m_ack, a read captures m_rdata into d_rdata or i_rdata. The matching done bit sets.
  - m_req and m_we drop at the same edge.
- Chaining: on m_ack in D_BUSY with i_req & ~i_done, the next state is I_BUSY directly, with no IDLE bubble. Otherwise the next state is IDLE.
- Done bits clear at any edge where stall=0, i.e. the edge where the core advances.
- A write sets d_done; d_rdata is unchanged.
- Timeout:
  - A wait counter clears on entry to a busy state and increments each busy cycle without m_ack.
  - When the counter reaches MAX_WAIT, the access aborts: rdata is loaded with 0, the done bit sets, timeout_err sets, and the state goes to IDLE.
  - timeout_err clears only on reset.
- Requests that drop while not yet done are ignored; the core never does this.

## Timing
- Reset value of every output and register is 0. State=IDLE, done bits=0, hold entry invalid.
- Reset mid-transaction: m_req drops asynchronously and memory must discard the access.
- Single access with m_ack in the first m_req cycle:
  - cycle0: IDLE, stall=1.
  - cycle1: m_req=1, ack.
  - cycle2: stall=0.
  - Result: 2 stall cycles.
- Both ports with zero-wait memory:
  - cycle1: D access.
  - cycle2: I access.
  - cycle3: stall=0.
  - Result: 3 stall cycles.
- Each extra memory wait cycle adds one stall cycle.
- i_rdata and d_rdata hold their value until the next completion on the same port.
- No requests: stall=0 and the state remains IDLE.

## Configuration
- Macro ARB_FETCH_HOLD_EN.
- Defined:
  - A one-entry fetch hold register {valid, addr, data} loads on every fetch completion that is not a timeout.
  - An i_req whose i_addr equals the held address while valid sets i_done immediately in IDLE, with no memory access. i_rdata takes the held data, so the fetch adds 0 stall cycles.
  - A D write completing to the held address clears valid. Because data has priority, a same-cycle fetch of that address then goes to memory and sees the new data.
- Undefined: every fetch, including a repeat of the same PC during a stall, performs a memory access, and no hold storage exists.

## Test plan
- Reset: assert reset mid-D_BUSY → m_req=0, stall=0, timeout_err=0 immediately; IDLE after release.
- Fetch only:
  - Stimulus: i_req=1, i_addr=0x100, m_ack in first cycle with m_rdata=0xE3A01005.
  - Required: m_addr=0x100, m_we=0; i_rdata=0xE3A01005; stall high exactly 2 cycles.
- Read then fetch:
  - Stimulus: d_req read 0x200 (m_rdata 0x12345678) plus i_req 0x104, both zero-wait.
  - Required: D issued first; I_BUSY follows with no IDLE; stall high 3 cycles; d_rdata=0x12345678.
- Wait states: d_we=1, 0x300, wdata=0xCAFEF00D, m_ack after 4 m_req cycles → m_wdata stable throughout; stall high 5 cycles; d_rdata unchanged.
- Timeout with MAX_WAIT=8 and m_ack never asserted → abort after 8 busy cycles; i_rdata=0; timeout_err=1 and stays 1 until reset.
- ARB_FETCH_HOLD_EN:
  - Repeat fetch: fetch 0x104 twice → second fetch has no m_req and 0 stall.
  - Write invalidation: a D write to 0x104, then a fetch of 0x104 → memory access occurs and returns the new data.
  - Macro undefined: the repeat fetch issues m_req.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one single-ported memory with pipeline stall.
// ARB_FETCH_HOLD_EN adds a one-entry fetch hold register for repeat PCs.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall,
  output logic          timeout_err
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    D_BUSY,
    I_BUSY
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          i_done;
  logic          d_done;
  logic [WW-1:0] wait_cnt;
  logic          i_pend;
  logic          d_pend;
  logic          hit;
  logic          expire;
  logic          go_d;
  logic          go_i;
  logic          ack_d;
  logic          ack_i;
  logic          to_d;
  logic          to_i;

  assign i_pend = i_req & ~i_done;
  assign d_pend = d_req & ~d_done;
  assign expire = (wait_cnt == WW'(MAX_WAIT - 1));
  assign stall  = ~reset & ((i_pend & ~hit) | d_pend);

`ifdef ARB_FETCH_HOLD_EN
  logic          hold_valid;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  // Only served from the hold when no data access could overwrite it first.
  assign hit = (state == IDLE) & hold_valid & i_pend & ~d_pend
             & (i_addr == hold_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else if (ack_i) begin
      hold_valid <= 1'b1;
      hold_addr  <= m_addr;
      hold_data  <= m_rdata;
    end else if (to_i) begin
      hold_valid <= 1'b0;
    end else if (ack_d & m_we & (m_addr == hold_addr)) begin
      hold_valid <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    go_d      = 1'b0;
    go_i      = 1'b0;
    ack_d     = 1'b0;
    ack_i     = 1'b0;
    to_d      = 1'b0;
    to_i      = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_pend) begin
          go_d      = 1'b1;
          state_nxt = D_BUSY;
        end else if (i_pend && !hit) begin
          go_i      = 1'b1;
          state_nxt = I_BUSY;
        end
      end
      D_BUSY: begin
        if (m_ack) begin
          ack_d = 1'b1;
          if (i_pend) begin
            go_i      = 1'b1;
            state_nxt = I_BUSY;
          end else begin
            state_nxt = IDLE;
          end
        end else if (expire) begin
          to_d      = 1'b1;
          state_nxt = IDLE;
        end
      end
      I_BUSY: begin
        if (m_ack) begin
          ack_i     = 1'b1;
          state_nxt = IDLE;
        end else if (expire) begin
          to_i      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      wait_cnt <= '0;
    end else begin
      if (go_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (go_i) begin
        m_req  <= 1'b1;
        m_we   <= 1'b0;
        m_addr <= i_addr;
      end else if (ack_d | ack_i | to_d | to_i) begin
        m_req <= 1'b0;
        m_we  <= 1'b0;
      end
      if (go_d | go_i)
        wait_cnt <= '0;
      else if (state != IDLE && !m_ack)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Done bits live until the core advances (the first edge with stall low).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (!stall) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (ack_i | to_i) i_done <= 1'b1;
      if (ack_d | to_d) d_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata <= '0;
    end else if (ack_i) begin
      i_rdata <= m_rdata;
    end else if (to_i) begin
      i_rdata <= '0;
`ifdef ARB_FETCH_HOLD_EN
    end else if (hit) begin
      i_rdata <= hold_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             d_rdata <= '0;
    else if (ack_d & ~m_we) d_rdata <= m_rdata;
    else if (to_d)         d_rdata <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            timeout_err <= 1'b0;
    else if (to_d | to_i) timeout_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: core + memory models and
// a transaction-level reference (access order, stall count, read data).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          stall;
  logic          timeout_err;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack(m_ack),
    .stall(stall),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
  } acc_t;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mem   [logic [31:0]];
  logic [31:0] model [logic [31:0]];
  int          waits_q[$];
  acc_t        log_q[$];
  bit          no_ack = 1'b0;
  bit          inflight;
  int          wl;
  acc_t        cur;
  logic [31:0] exp_i;
  logic [31:0] exp_d;
  logic [31:0] exp_terr;
  bit          hv;
  logic [31:0] ha;
  logic [31:0] last_ia;
  int          cyc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model.exists(a) ? model[a] : init_val(a);
  endfunction

  // Memory: logs each transaction, acks after the queued wait count.
  initial begin
    m_ack    = 1'b0;
    m_rdata  = '0;
    inflight = 1'b0;
    wl       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_ack) inflight = 1'b0;
      m_ack = 1'b0;
      if (reset || !m_req) begin
        inflight = 1'b0;
        continue;
      end
      if (!inflight) begin
        inflight = 1'b1;
        cur = '{a: m_addr, we: m_we, wd: m_wdata};
        log_q.push_back(cur);
        wl = (no_ack || waits_q.size() == 0) ? 0 : waits_q.pop_front();
      end else begin
        check("m_addr_stable", m_addr, cur.a);
        check("m_we_stable", 32'(m_we), 32'(cur.we));
        check("m_wdata_stable", m_wdata, cur.wd);
      end
      if (no_ack) continue;
      if (wl == 0) begin
        m_ack = 1'b1;
        if (cur.we) begin
          mem[cur.a] = cur.wd;
          m_rdata = $urandom;
        end else begin
          m_rdata = mem_rd(cur.a);
        end
      end else begin
        wl--;
      end
    end
  end

  task automatic wait_stall(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n >= 60) begin
        check("stall_bound", 32'(stall), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // One core step: drive the requests, expect the reference outcome.
  task automatic step(input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dw, input logic [31:0] da,
                      input logic [31:0] dwd, input int wd, input int wi);
    acc_t exp_q[$];
    int   exp_st;
    int   n;
    bit   hit;
    exp_st = 0;
    waits_q.delete();
    if (dr) begin
      exp_q.push_back('{a: da, we: dw, wd: dw ? dwd : 32'h0});
      waits_q.push_back(wd);
      exp_st += 1 + wd;
      if (dw) begin
        model[da] = dwd;
        if (hv && ha == da) hv = 1'b0;
      end else begin
        exp_d = model_rd(da);
      end
    end
    hit = 1'b0;
`ifdef ARB_FETCH_HOLD_EN
    hit = ir && !dr && hv && (ha == ia);
`endif
    if (ir) begin
      exp_i = model_rd(ia);
      if (!hit) begin
        exp_q.push_back('{a: ia, we: 1'b0, wd: 32'h0});
        waits_q.push_back(wi);
        exp_st += 1 + wi;
        hv = 1'b1;
        ha = ia;
      end
    end
    if (exp_st > 0) exp_st += 1;
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    wait_stall(n);
    check("stall_cycles", 32'(n), 32'(exp_st));
    check("i_rdata", i_rdata, exp_i);
    check("d_rdata", d_rdata, exp_d);
    check("timeout_err", 32'(timeout_err), exp_terr);
    check("n_access", 32'(log_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      check("acc_addr", log_q[k].a, exp_q[k].a);
      check("acc_we", 32'(log_q[k].we), 32'(exp_q[k].we));
      if (exp_q[k].we) check("acc_wdata", log_q[k].wd, exp_q[k].wd);
    end
    log_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          ir;
    bit          dr;
    bit          dw;
    logic [31:0] ia;
    logic [31:0] da;
    reset    = 1'b1;
    i_req    = 1'b0;
    i_addr   = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    exp_i    = '0;
    exp_d    = '0;
    exp_terr = '0;
    hv       = 1'b0;
    ha       = '0;
    last_ia  = 32'h100;
    mem[32'h100]   = 32'hE3A0_1005;
    model[32'h100] = 32'hE3A0_1005;
    mem[32'h200]   = 32'h1234_5678;
    model[32'h200] = 32'h1234_5678;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;

    step(1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 32'h104, 1, 0, 32'h200, 32'h0, 0, 0);
    step(0, 32'h0, 1, 1, 32'h300, 32'hCAFE_F00D, 3, 0);
    step(1, 32'h104, 0, 0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 1, 1, 32'h104, 32'hDEAD_BEEF, 0, 0);
    step(1, 32'h104, 0, 0, 32'h0, 32'h0, 1, 2);
    step(1, 32'h104, 1, 1, 32'h104, 32'h0BAD_F00D, 1, 0);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

    for (int s = 0; s < 150; s++) begin
      ir = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 1) == 1) ia = last_ia;
      else ia = 32'h100 + 32'(4 * $urandom_range(0, 3));
      last_ia = ia;
      dr = ($urandom_range(0, 9) < 4);
      dw = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) da = 32'h200 + 32'(4 * $urandom_range(0, 1));
      else da = 32'h100 + 32'(4 * $urandom_range(0, 3));
      step(ir, ia, dr, dw, da, $urandom,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Fetch that never gets an ack.
    no_ack = 1'b1;
    waits_q.delete();
    i_req  = 1'b1;
    i_addr = 32'h180;
    d_req  = 1'b0;
    wait_stall(cyc);
    check("to_stall_cycles", 32'(cyc), 32'(1 + MW));
    check("to_i_rdata", i_rdata, 32'd0);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_access", 32'(log_q.size()), 32'd1);
    log_q.delete();
    exp_i    = '0;
    exp_terr = 32'd1;
    hv       = 1'b0;
    @(posedge clk);
    #1;
    i_req  = 1'b0;
    no_ack = 1'b0;
    step(1, 32'h1C0, 0, 0, 32'h0, 32'h0, 1, 1);

    // Reset while a data access is outstanding.
    no_ack = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h200;
    i_req  = 1'b1;
    i_addr = 32'h104;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_m_req", 32'(m_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_m_req", 32'(m_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_err", 32'(timeout_err), 32'd0);
    i_req  = 1'b0;
    d_req  = 1'b0;
    no_ack = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_rst_m_req", 32'(m_req), 32'd0);
      check("post_rst_stall", 32'(stall), 32'd0);
    end
    log_q.delete();
    exp_i    = '0;
    exp_d    = '0;
    exp_terr = '0;
    hv       = 1'b0;
    @(posedge clk);
    #1;
    step(1, 32'h104, 1, 0, 32'h200, 32'h0, 0, 1);
    step(1, 32'h104, 0, 0, 32'h0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
